div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Sequencer for the repeated-subtraction divider datapath (divisor/dividend/accumulator PIPOs, w-vs-divisor comparator, subtractor, quotient up-counter).
- Accepts a request with operands, captures them, and drives the shared data_in bus and the ldb/ldp/lda/ldc/inc/sel strobes.
- Iterates on the comparator result, then signals completion with divide-by-zero and iteration-limit error flags.
- Replaces fixed-step hand sequencing with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand, data bus and iteration-counter width
MAX_ITER, 16'hFFFF, subtraction limit before abort; must be >= 1

Ports:
clk  input  1  clock, all state on posedge
clr  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
dividend_i  input  WIDTH  dividend; captured on accept
divisor_i  input  WIDTH  divisor; captured on accept
lt  input  1  comparator: w < divisor
gt  input  1  comparator: w > divisor (monitored only)
eq  input  1  comparator: w == divisor (monitored only)
data_out  output  WIDTH  drives datapath data_in
ldb  output  1  load divisor register
ldp  output  1  load dividend register
lda  output  1  load accumulator with w - divisor
ldc  output  1  load quotient counter with 0
inc  output  1  increment quotient counter
sel  output  1  w source: 0 = dividend, 1 = accumulator
busy  output  1  high when state != IDLE
done  output  1  one-cycle completion pulse
err_dz  output  1  divisor was zero; valid with done, held until next accept
err_ovf  output  1  MAX_ITER reached; valid with done, held until next accept
iter_cnt  output  WIDTH  subtractions performed this operation

Behaviour:
- Reset (async, any state): state=IDLE. Outputs 0: data_out, sel, err_dz, err_ovf, iter_cnt, all strobes, busy, done. Datapath registers are not cleared.
- States: IDLE, LDB, LDP, LOOP, DONE, ERR.
- Strobes ldb/ldp/lda/ldc/inc/done are combinational from state and lt, and are 0 outside the listed states.
- sel, data_out, err flags and iter_cnt are registered.

IDLE:
- start=1 accepts the request.
  - Capture both operands internally.
  - Clear sel, iter_cnt, err_dz, err_ovf.
  - Next state: ERR if divisor_i==0, else LDB.
- start=0: stay in IDLE.

LDB:
- data_out=divisor, ldb=1, ldc=1 (quotient counter loads 0).
- Next state: LDP.

LDP:
- data_out=dividend, ldp=1.
- Next state: LOOP.

LOOP (one subtraction per cycle):
- If lt=1: next state DONE, no strobes.
- Else if iter_cnt==MAX_ITER: set err_ovf, next state DONE, no strobes.
- Else:
  - lda=1, inc=1; sel keeps its registered value (0 on the first pass).
  - Register sel<=1 and iter_cnt<=iter_cnt+1.
  - Stay in LOOP.
- eq=1 counts as "not lt": a subtraction is performed, leaving remainder 0.

DONE:
- done=1 for one cycle; next state IDLE.
- Quotient is on the datapath counter output; remainder is on w.
- sel keeps its value after DONE, so w keeps showing the remainder until the next accept.

ERR:
- done=1, err_dz=1, no datapath strobes; next state IDLE.

Latency and handshake:
- Accept at cycle T; quotient q with no abort: LDB T+1, LDP T+2, LOOP T+3..T+3+q, done at T+4+q.
- Divide-by-zero: done at T+1.
- start while busy is ignored and not queued.
- start held high across DONE is re-accepted on the first IDLE cycle (back-to-back operation).
- data_out holds its last value when not loading.
- Exactly one strobe set per state as listed; ldb and ldp are never high in the same cycle.

Test Plan:
- 100/7, MAX_ITER default: inc high 14 cycles, done at T+18, quotient 14, remainder 2, iter_cnt 14, sel=1, no errors.
- 6/7: no lda/inc, done at T+4, quotient 0, sel=0, w=6.
- 21/7 (eq path): 3 subtractions, quotient 3, remainder 0, done at T+7.
- 0/5: quotient 0, remainder 0, done at T+4.
- divisor 0, dividend 9: done and err_dz at T+1, no ldb/ldp/lda/ldc/inc ever asserted, busy for 1 cycle.
- MAX_ITER=4, 100/7: exactly 4 inc pulses, err_ovf=1, done at T+8, quotient 4.
- Restart and busy-start: assert clr mid-LOOP of 100/7 → all outputs 0 immediately, IDLE. A new 50/5 then gives quotient 10, remainder 0, and a start pulse during its busy window is ignored.

Source files
------------

// File: rtl/div_seq_ctrl_if.sv
// Request/response and datapath strobe bundle for the repeated-subtraction divider sequencer.
interface div_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             lt;
   logic             gt;
   logic             eq;
   logic [WIDTH-1:0] data_out;
   logic             ldb;
   logic             ldp;
   logic             lda;
   logic             ldc;
   logic             inc;
   logic             sel;
   logic             busy;
   logic             done;
   logic             err_dz;
   logic             err_ovf;
   logic [WIDTH-1:0] iter_cnt;

   modport master (
      output start, dividend_i, divisor_i, lt, gt, eq,
      input  data_out, ldb, ldp, lda, ldc, inc, sel, busy, done, err_dz, err_ovf, iter_cnt
   );

   modport slave (
      input  start, dividend_i, divisor_i, lt, gt, eq,
      output data_out, ldb, ldp, lda, ldc, inc, sel, busy, done, err_dz, err_ovf, iter_cnt
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for the repeated-subtraction divider: loads divisor/dividend over the
// shared data bus, iterates on the comparator, reports done with error flags.
module div_seq_ctrl #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] MAX_ITER = 16'hFFFF
) (
   input logic          clk,
   input logic          clr,
   div_seq_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LDB  = 3'd1;
   localparam logic [2:0] S_LDP  = 3'd2;
   localparam logic [2:0] S_LOOP = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic [2:0]       state;
   logic [WIDTH-1:0] dvd_q;
   logic             at_limit;
   logic             sub_go;

   assign at_limit = (bus.iter_cnt == MAX_ITER);
   // eq falls through here as "not lt", so an exact match still subtracts once more
   assign sub_go   = (state == S_LOOP) && !bus.lt && !at_limit;

   assign bus.ldb  = (state == S_LDB);
   assign bus.ldc  = (state == S_LDB);
   assign bus.ldp  = (state == S_LDP);
   assign bus.lda  = sub_go;
   assign bus.inc  = sub_go;
   assign bus.done = (state == S_DONE) || (state == S_ERR);
   assign bus.busy = (state != S_IDLE);

   // The divisor is captured straight into data_out so it is on the bus during LDB.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state        <= S_IDLE;
         dvd_q        <= '0;
         bus.data_out <= '0;
         bus.sel      <= 1'b0;
         bus.err_dz   <= 1'b0;
         bus.err_ovf  <= 1'b0;
         bus.iter_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  dvd_q        <= bus.dividend_i;
                  bus.sel      <= 1'b0;
                  bus.iter_cnt <= '0;
                  bus.err_ovf  <= 1'b0;
                  if (bus.divisor_i == '0) begin
                     bus.err_dz <= 1'b1;
                     state      <= S_ERR;
                  end else begin
                     bus.err_dz   <= 1'b0;
                     bus.data_out <= bus.divisor_i;
                     state        <= S_LDB;
                  end
               end
            end
            S_LDB: begin
               bus.data_out <= dvd_q;
               state        <= S_LDP;
            end
            S_LDP: state <= S_LOOP;
            S_LOOP: begin
               if (bus.lt) begin
                  state <= S_DONE;
               end else if (at_limit) begin
                  bus.err_ovf <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  bus.sel      <= 1'b1;
                  bus.iter_cnt <= bus.iter_cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
